cnn_core_div_21s_5ns_16_seq: RTL and testbench



---
 rtl/cnn_core_div_pkg.sv | 29 ++
 rtl/cnn_core_div_step.sv | 25 ++
 rtl/cnn_core_div_21s_5ns_16_seq.sv | 102 ++++++++++
 tb/tb_cnn_core_div_21s_5ns_16_seq.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/cnn_core_div_pkg.sv
// cnn_core_div_pkg: shared widths, FSM states, saturation limits and helpers for the
// 21s / 5ns -> 16 sequential divider.
//   DIVIDEND_WIDTH : signed dividend width
//   DIVISOR_WIDTH  : unsigned divisor width
//   QUOT_WIDTH     : saturating signed quotient width
//   REM_WIDTH      : signed remainder width, also the partial-remainder width
package cnn_core_div_pkg;
    localparam int DIVIDEND_WIDTH = 21;
    localparam int DIVISOR_WIDTH  = 5;
    localparam int QUOT_WIDTH     = 16;
    localparam int REM_WIDTH      = DIVISOR_WIDTH + 1;
    localparam int CNT_WIDTH      = $clog2(DIVIDEND_WIDTH);

    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(DIVIDEND_WIDTH - 1);

    localparam logic signed [QUOT_WIDTH-1:0] QMAX = {1'b0, {(QUOT_WIDTH-1){1'b1}}};
    localparam logic signed [QUOT_WIDTH-1:0] QMIN = {1'b1, {(QUOT_WIDTH-1){1'b0}}};

    // Largest quotient magnitudes representable for positive / negative results.
    localparam logic [DIVIDEND_WIDTH-1:0] POS_LIM = DIVIDEND_WIDTH'((1 << (QUOT_WIDTH-1)) - 1);
    localparam logic [DIVIDEND_WIDTH-1:0] NEG_LIM = DIVIDEND_WIDTH'(1 << (QUOT_WIDTH-1));

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // Magnitude as unsigned: -2^(W-1) maps to 2^(W-1) without wrapping.
    function automatic logic [DIVIDEND_WIDTH-1:0] abs_mag(input logic signed [DIVIDEND_WIDTH-1:0] v);
        return v[DIVIDEND_WIDTH-1] ? $unsigned(-v) : $unsigned(v);
    endfunction
endpackage

// File: rtl/cnn_core_div_step.sv
// cnn_core_div_step: one combinational restoring-division iteration.
//   part      : current partial remainder (always < divisor)
//   bit_in    : next dividend bit, MSB first
//   divisor   : unsigned divisor
//   part_next : partial remainder after this iteration
//   q_bit     : quotient bit produced by this iteration
module cnn_core_div_step
    import cnn_core_div_pkg::*;
(
    input  logic [REM_WIDTH-1:0]     part,
    input  logic                     bit_in,
    input  logic [DIVISOR_WIDTH-1:0] divisor,
    output logic [REM_WIDTH-1:0]     part_next,
    output logic                     q_bit
);
    logic [REM_WIDTH:0] shifted;
    logic [REM_WIDTH:0] dvs_ext;

    always_comb begin
        shifted   = {part, bit_in};
        dvs_ext   = {2'b00, divisor};
        q_bit     = shifted >= dvs_ext;
        part_next = REM_WIDTH'(q_bit ? shifted - dvs_ext : shifted);
    end
endmodule

// File: rtl/cnn_core_div_21s_5ns_16_seq.sv
// cnn_core_div_21s_5ns_16_seq: sequential signed/unsigned divider, one quotient bit per cycle.
//   ap_clk, ap_rst           : clock and asynchronous active-high reset
//   in_valid / in_ready      : operand handshake (ready only when idle)
//   dividend, divisor        : 21-bit signed dividend, 5-bit unsigned divisor
//   out_valid / out_ready    : result handshake, result held until accepted
//   quotient, remainder      : saturated truncating quotient, remainder with dividend sign
//   div_by_zero, overflow    : result flags
module cnn_core_div_21s_5ns_16_seq
    import cnn_core_div_pkg::*;
(
    input  logic                             ap_clk,
    input  logic                             ap_rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic signed [DIVIDEND_WIDTH-1:0] dividend,
    input  logic        [DIVISOR_WIDTH-1:0]  divisor,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic signed [QUOT_WIDTH-1:0]     quotient,
    output logic signed [REM_WIDTH-1:0]      remainder,
    output logic                             div_by_zero,
    output logic                             overflow
);
    state_t                     state;
    logic [CNT_WIDTH-1:0]       cnt;
    logic [DIVIDEND_WIDTH-1:0]  mag;
    logic [REM_WIDTH-1:0]       part;
    logic [REM_WIDTH-1:0]       part_next;
    logic [DIVISOR_WIDTH-1:0]   dvs;
    logic                       neg;
    logic                       q_bit;
    logic                       dz_fin;
    logic                       ovf_fin;
    logic signed [QUOT_WIDTH-1:0] q_fin;
    logic signed [REM_WIDTH-1:0]  r_fin;

    assign in_ready = state == IDLE;

    // mag shifts dividend bits out of the top while quotient bits enter at the bottom,
    // so after DIVIDEND_WIDTH iterations it holds the quotient magnitude.
    cnn_core_div_step u_step (
        .part      (part),
        .bit_in    (mag[DIVIDEND_WIDTH-1]),
        .divisor   (dvs),
        .part_next (part_next),
        .q_bit     (q_bit)
    );

    always_comb begin
        dz_fin  = dvs == '0;
        ovf_fin = !dz_fin && (neg ? mag > NEG_LIM : mag > POS_LIM);
        q_fin   = (dz_fin || ovf_fin) ? (neg ? QMIN : QMAX)
                : (neg ? -$signed(mag[QUOT_WIDTH-1:0]) : $signed(mag[QUOT_WIDTH-1:0]));
        r_fin   = dz_fin ? '0 : (neg ? -$signed(part) : $signed(part));
    end

    // DONE is entered with out_valid low; its first cycle latches the signed,
    // saturated result, then the result is held until out_ready.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            mag         <= '0;
            part        <= '0;
            dvs         <= '0;
            neg         <= 1'b0;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    neg   <= dividend[DIVIDEND_WIDTH-1];
                    mag   <= abs_mag(dividend);
                    dvs   <= divisor;
                    part  <= '0;
                    cnt   <= CNT_INIT;
                    state <= divisor == '0 ? DONE : CALC;
                end
                CALC: begin
                    mag  <= {mag[DIVIDEND_WIDTH-2:0], q_bit};
                    part <= part_next;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) state <= DONE;
                end
                DONE: if (!out_valid) begin
                    out_valid   <= 1'b1;
                    quotient    <= q_fin;
                    remainder   <= r_fin;
                    div_by_zero <= dz_fin;
                    overflow    <= ovf_fin;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cnn_core_div_21s_5ns_16_seq.sv
// tb_cnn_core_div_21s_5ns_16_seq: directed table, corner sequences and random ops vs integer model.
module tb_cnn_core_div_21s_5ns_16_seq;
    logic               ap_clk = 0;
    logic               ap_rst = 1;
    logic               in_valid = 0;
    logic               out_ready = 0;
    logic signed [20:0] dividend = '0;
    logic        [4:0]  divisor = '0;
    logic               in_ready, out_valid, div_by_zero, overflow;
    logic signed [15:0] quotient;
    logic signed [5:0]  remainder;

    int vectors = 0;
    int miscompares = 0;
    int g_q, g_r, g_dz, g_ov, g_lat;

    typedef struct {
        int dd; int ds; int q; int r; int dz; int ov; int lat;
    } vec_t;

    cnn_core_div_21s_5ns_16_seq dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string name, input int got, input int exp);
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Truncating integer division with the output saturation and divide-by-zero rules.
    function automatic void model(input int dd, input int ds, output int q, output int r,
                                  output int dz, output int ov);
        dz = 0; ov = 0;
        if (ds == 0) begin
            dz = 1; r = 0; q = dd < 0 ? -32768 : 32767;
        end else begin
            q = dd / ds; r = dd % ds;
            if (q > 32767) begin q = 32767; ov = 1; end
            else if (q < -32768) begin q = -32768; ov = 1; end
        end
    endfunction

    // Issue one op, measure edges until out_valid, optionally stall out_ready, then retire it.
    task automatic run_op(input int dd, input int ds, input int hold);
        int n = 0;
        while (!in_ready && n < 50) begin @(posedge ap_clk); #1; n++; end
        dividend = 21'(dd); divisor = 5'(ds); in_valid = 1;
        @(posedge ap_clk); #1;
        in_valid = 0;
        g_lat = 0;
        while (!out_valid && g_lat < 40) begin @(posedge ap_clk); #1; g_lat++; end
        if (!out_valid) begin
            chk("out_valid_timeout", 0, 1);
            g_q = -99999; g_r = -99999; g_dz = -1; g_ov = -1;
            ap_rst = 1; #2; ap_rst = 0;
            return;
        end
        g_q = int'(quotient); g_r = int'(remainder); g_dz = int'(div_by_zero); g_ov = int'(overflow);
        for (int i = 0; i < hold; i++) begin
            @(posedge ap_clk); #1;
            chk("hold_out_valid", int'(out_valid), 1);
            chk("hold_in_ready", int'(in_ready), 0);
            chk("hold_quotient", int'(quotient), g_q);
            chk("hold_remainder", int'(remainder), g_r);
            chk("hold_flags", int'({div_by_zero, overflow}), int'({g_dz[0], g_ov[0]}));
        end
        out_ready = 1;
        @(posedge ap_clk); #1;
        out_ready = 0;
        chk("retire_out_valid", int'(out_valid), 0);
        chk("retire_in_ready", int'(in_ready), 1);
    endtask

    initial begin
        vec_t tbl[14];
        int seen;
        tbl[0]  = '{1000, 7, 142, 6, 0, 0, 22};
        tbl[1]  = '{-1000, 7, -142, -6, 0, 0, 22};
        tbl[2]  = '{-21, 7, -3, 0, 0, 0, 22};
        tbl[3]  = '{500000, 3, 32767, 2, 0, 1, 22};
        tbl[4]  = '{-1048576, 1, -32768, 0, 0, 1, 22};
        tbl[5]  = '{-5, 0, -32768, 0, 1, 0, 1};
        tbl[6]  = '{7, 0, 32767, 0, 1, 0, 1};
        tbl[7]  = '{0, 0, 32767, 0, 1, 0, 1};
        tbl[8]  = '{32767, 1, 32767, 0, 0, 0, 22};
        tbl[9]  = '{-32768, 1, -32768, 0, 0, 0, 22};
        tbl[10] = '{32768, 1, 32767, 0, 0, 1, 22};
        tbl[11] = '{1048575, 31, 32767, 0, 0, 1, 22};
        tbl[12] = '{-30, 31, 0, -30, 0, 0, 22};
        tbl[13] = '{-1048576, 31, -32768, -1, 0, 1, 22};

        repeat (3) @(posedge ap_clk);
        #1;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_quotient", int'(quotient), 0);
        chk("reset_remainder", int'(remainder), 0);
        chk("reset_flags", int'({div_by_zero, overflow}), 0);
        ap_rst = 0;
        @(posedge ap_clk); #1;

        foreach (tbl[i]) begin
            run_op(tbl[i].dd, tbl[i].ds, 0);
            vectors++;
            chk($sformatf("tbl%0d_quotient", i), g_q, tbl[i].q);
            chk($sformatf("tbl%0d_remainder", i), g_r, tbl[i].r);
            chk($sformatf("tbl%0d_div_by_zero", i), g_dz, tbl[i].dz);
            chk($sformatf("tbl%0d_overflow", i), g_ov, tbl[i].ov);
            chk($sformatf("tbl%0d_latency", i), g_lat, tbl[i].lat);
        end

        // Backpressure: result held for 10 stalled cycles.
        run_op(-1000, 7, 10);
        vectors++;
        chk("bp_quotient", g_q, -142);
        chk("bp_remainder", g_r, -6);

        // Asynchronous reset in the middle of CALC discards the op.
        dividend = 21'(1000); divisor = 5'd7; in_valid = 1;
        @(posedge ap_clk); #1;
        in_valid = 0;
        repeat (10) @(posedge ap_clk);
        #3 ap_rst = 1;
        #1;
        vectors++;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_quotient", int'(quotient), 0);
        chk("midrst_remainder", int'(remainder), 0);
        chk("midrst_flags", int'({div_by_zero, overflow}), 0);
        #1 ap_rst = 0;
        seen = 0;
        repeat (25) begin @(posedge ap_clk); #1; seen += int'(out_valid); end
        chk("midrst_no_result", seen, 0);
        run_op(1000, 7, 0);
        vectors++;
        chk("post_rst_quotient", g_q, 142);
        chk("post_rst_remainder", g_r, 6);
        chk("post_rst_flags", g_dz + g_ov, 0);
        chk("post_rst_latency", g_lat, 22);

        for (int k = 0; k < 2500; k++) begin
            logic signed [20:0] r21;
            int dd, ds, q, r, dz, ov;
            r21 = 21'($urandom);
            if ($urandom_range(1) == 1) r21 = r21 >>> $urandom_range(20);
            dd = int'(r21);
            ds = int'($urandom_range(31));
            model(dd, ds, q, r, dz, ov);
            run_op(dd, ds, 0);
            vectors++;
            chk($sformatf("rnd %0d/%0d quotient", dd, ds), g_q, q);
            chk($sformatf("rnd %0d/%0d remainder", dd, ds), g_r, r);
            chk($sformatf("rnd %0d/%0d div_by_zero", dd, ds), g_dz, dz);
            chk($sformatf("rnd %0d/%0d overflow", dd, ds), g_ov, ov);
            chk($sformatf("rnd %0d/%0d latency", dd, ds), g_lat, ds == 0 ? 1 : 22);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
